flash_xip_arbiter: RTL and testbench



---
 rtl/flash_xip_arbiter.sv | 135 +++++++++++++
 tb/tb_flash_xip_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_xip_arbiter.sv
// Round-robin, read-only arbiter sharing the XIP flash AHB-Lite port between
// two OBI requesters; writes are answered with an error response.
module flash_xip_arbiter #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned IdWidth   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             req_i,
  input  logic [2*AddrWidth-1:0] addr_i,
  input  logic [1:0]             we_i,
  input  logic [2*IdWidth-1:0]   aid_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   err_o,
  output logic [IdWidth-1:0]     rid_o,
  output logic                   hsel_o,
  output logic [AddrWidth-1:0]   haddr_o,
  output logic [1:0]             htrans_o,
  output logic                   hwrite_o,
  output logic                   hready_o,
  input  logic                   hreadyout_i,
  input  logic [31:0]            hrdata_i,
  output logic                   busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_ERR
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_en;
  logic                   r_last;
  logic                   r_port;
  logic [AddrWidth-1:2]   r_addr;
  logic [IdWidth-1:0]     r_aid;
  logic [31:0]            r_rdata;

  logic                   w_win;
  logic                   w_take;
  logic [AddrWidth-1:0]   w_addr_win;
  logic [IdWidth-1:0]     w_aid_win;
  logic                   w_unused_lsb;

  // Lone requester wins; on a tie the port that did not win last time goes.
  assign w_win      = (req_i == 2'b11) ? ~r_last : req_i[1];
  assign w_take     = (r_state == S_IDLE) && r_en && (|req_i);
  assign w_addr_win = w_win ? addr_i[2*AddrWidth-1:AddrWidth] : addr_i[AddrWidth-1:0];
  assign w_aid_win  = w_win ? aid_i[2*IdWidth-1:IdWidth] : aid_i[IdWidth-1:0];

  // Byte-offset bits are dropped: the AHB side is always word aligned.
  assign w_unused_lsb = ^{addr_i[AddrWidth+1:AddrWidth], addr_i[1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_en    <= 1'b0;
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_addr  <= '0;
      r_aid   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= 1'b1;
      if (w_take) begin
        r_last <= w_win;
        r_port <= w_win;
        r_addr <= w_addr_win[AddrWidth-1:2];
        r_aid  <= w_aid_win;
      end
      if (r_state == S_DATA && hreadyout_i) begin
        r_rdata <= hrdata_i;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_take) w_state_nxt = we_i[w_win] ? S_ERR : S_ADDR;
      S_ADDR: if (hreadyout_i) w_state_nxt = S_DATA;
      S_DATA: if (hreadyout_i) w_state_nxt = S_RESP;
      S_RESP: w_state_nxt = S_IDLE;
      S_ERR:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = 1'b0;
    rid_o    = '0;
    hsel_o   = 1'b0;
    haddr_o  = '0;
    htrans_o = HTRANS_IDLE;
    busy_o   = (r_state != S_IDLE);
    if (w_take) begin
      gnt_o = w_win ? 2'b10 : 2'b01;
    end
    unique case (r_state)
      S_ADDR: begin
        hsel_o   = 1'b1;
        htrans_o = HTRANS_NONSEQ;
        haddr_o  = {r_addr, 2'b00};
      end
      S_RESP: begin
        rvalid_o = r_port ? 2'b10 : 2'b01;
        rdata_o  = r_rdata;
        rid_o    = r_aid;
      end
      S_ERR: begin
        rvalid_o = r_port ? 2'b10 : 2'b01;
        err_o    = 1'b1;
        rid_o    = r_aid;
      end
      default: ;
    endcase
  end

  assign hwrite_o = 1'b0;
  assign hready_o = hreadyout_i;

endmodule

// File: tb/tb_flash_xip_arbiter.sv
// Directed bench for flash_xip_arbiter: single read, wait states, misaligned
// address with ADDR stall, write rejection, reset mid-DATA and round-robin.
module tb_flash_xip_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_i;
  logic [63:0] addr_i;
  logic [1:0]  we_i;
  logic [1:0]  aid_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [0:0]  rid_o;
  logic        hsel_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic        hready_o;
  logic        hreadyout_i;
  logic [31:0] hrdata_i;
  logic        busy_o;

  int checks   = 0;
  int failures = 0;

  flash_xip_arbiter #(.AddrWidth(32), .IdWidth(1)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .aid_i       (aid_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .rid_o       (rid_o),
    .hsel_o      (hsel_o),
    .haddr_o     (haddr_o),
    .htrans_o    (htrans_o),
    .hwrite_o    (hwrite_o),
    .hready_o    (hready_o),
    .hreadyout_i (hreadyout_i),
    .hrdata_i    (hrdata_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_resp(input string tag);
    chk({tag, "_rvalid"}, 64'(rvalid_o), 64'h0);
    chk({tag, "_err"},    64'(err_o),    64'h0);
    chk({tag, "_rdata"},  64'(rdata_o),  64'h0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_i       = 2'b00;
    addr_i      = '0;
    we_i        = 2'b00;
    aid_i       = 2'b00;
    hreadyout_i = 1'b1;
    hrdata_i    = '0;
    #12;

    chk("rst_gnt",    64'(gnt_o),    64'h0);
    chk("rst_rvalid", 64'(rvalid_o), 64'h0);
    chk("rst_rdata",  64'(rdata_o),  64'h0);
    chk("rst_err",    64'(err_o),    64'h0);
    chk("rst_rid",    64'(rid_o),    64'h0);
    chk("rst_hsel",   64'(hsel_o),   64'h0);
    chk("rst_htrans", 64'(htrans_o), 64'h0);
    chk("rst_haddr",  64'(haddr_o),  64'h0);
    chk("rst_hwrite", 64'(hwrite_o), 64'h0);
    chk("rst_busy",   64'(busy_o),   64'h0);

    // Release reset; first cycle has the enable still low.
    tick();
    rst_ni = 1'b1;
    req_i  = 2'b01;
    addr_i = 64'h0000_0000_0000_0104;
    aid_i  = 2'b01;
    #1;
    chk("en_gnt0", 64'(gnt_o), 64'h0);

    // Single read, zero wait states.
    tick();
    chk("rd_gnt", 64'(gnt_o), 64'h1);
    chk("rd_busyT", 64'(busy_o), 64'h0);
    tick();
    req_i = 2'b00;
    #1;
    chk("rd_hsel",   64'(hsel_o),   64'h1);
    chk("rd_htrans", 64'(htrans_o), 64'h2);
    chk("rd_haddr",  64'(haddr_o),  64'h104);
    chk("rd_hwrite", 64'(hwrite_o), 64'h0);
    chk("rd_busy",   64'(busy_o),   64'h1);
    chk("rd_gnt_addr", 64'(gnt_o),  64'h0);
    tick();
    hrdata_i = 32'hDEAD_BEEF;
    #1;
    chk("rd_data_hsel",   64'(hsel_o),   64'h0);
    chk("rd_data_htrans", 64'(htrans_o), 64'h0);
    chk_idle_resp("rd_data");
    tick();
    chk("rd_rvalid", 64'(rvalid_o), 64'h1);
    chk("rd_rdata",  64'(rdata_o),  64'hDEAD_BEEF);
    chk("rd_rid",    64'(rid_o),    64'h1);
    chk("rd_err",    64'(err_o),    64'h0);
    tick();
    chk_idle_resp("rd_after");
    chk("rd_after_busy", 64'(busy_o), 64'h0);

    // Same read with three DATA wait states.
    req_i = 2'b01;
    #1;
    chk("ws_gnt", 64'(gnt_o), 64'h1);
    tick();
    req_i = 2'b00;
    #1;
    chk("ws_haddr", 64'(haddr_o), 64'h104);
    tick();
    hreadyout_i = 1'b0;
    hrdata_i    = 32'h1234_5678;
    #1;
    chk("ws_hready_o", 64'(hready_o), 64'h0);
    chk_idle_resp("ws_t2");
    tick();
    chk_idle_resp("ws_t3");
    tick();
    chk_idle_resp("ws_t4");
    tick();
    hreadyout_i = 1'b1;
    #1;
    chk_idle_resp("ws_t5");
    tick();
    chk("ws_rvalid", 64'(rvalid_o), 64'h1);
    chk("ws_rdata",  64'(rdata_o),  64'h1234_5678);
    tick();

    // Misaligned address, one ADDR wait state.
    req_i  = 2'b01;
    addr_i = 64'h0000_0000_0000_0107;
    aid_i  = 2'b00;
    #1;
    chk("mis_gnt", 64'(gnt_o), 64'h1);
    tick();
    req_i       = 2'b00;
    hreadyout_i = 1'b0;
    #1;
    chk("mis_haddr0",  64'(haddr_o),  64'h104);
    chk("mis_hsel0",   64'(hsel_o),   64'h1);
    tick();
    hreadyout_i = 1'b1;
    #1;
    chk("mis_haddr1",  64'(haddr_o),  64'h104);
    chk("mis_htrans1", 64'(htrans_o), 64'h2);
    tick();
    hrdata_i = 32'hCAFE_F00D;
    #1;
    chk("mis_data_hsel", 64'(hsel_o), 64'h0);
    tick();
    chk("mis_rvalid", 64'(rvalid_o), 64'h1);
    chk("mis_rdata",  64'(rdata_o),  64'hCAFE_F00D);
    chk("mis_rid",    64'(rid_o),    64'h0);
    tick();

    // Write from port 1 is rejected without AHB traffic.
    req_i  = 2'b10;
    we_i   = 2'b10;
    aid_i  = 2'b00;
    addr_i = 64'h0000_0500_0000_0000;
    #1;
    chk("wr_gnt",  64'(gnt_o),  64'h2);
    chk("wr_hsel", 64'(hsel_o), 64'h0);
    tick();
    chk("wr_rvalid", 64'(rvalid_o), 64'h2);
    chk("wr_err",    64'(err_o),    64'h1);
    chk("wr_rdata",  64'(rdata_o),  64'h0);
    chk("wr_rid",    64'(rid_o),    64'h0);
    chk("wr_hsel1",  64'(hsel_o),   64'h0);
    chk("wr_gnt_err", 64'(gnt_o),   64'h0);
    tick();
    chk("wr_gnt2", 64'(gnt_o), 64'h2);
    tick();
    req_i = 2'b00;
    #1;
    chk("wr2_rvalid", 64'(rvalid_o), 64'h2);
    chk("wr2_err",    64'(err_o),    64'h1);
    chk("wr2_hsel",   64'(hsel_o),   64'h0);
    tick();
    we_i = 2'b00;
    #1;
    chk("wr_after_busy", 64'(busy_o), 64'h0);

    // Reset asserted while the read sits in DATA.
    req_i  = 2'b01;
    addr_i = 64'h0000_0000_0000_0200;
    aid_i  = 2'b01;
    #1;
    chk("rm_gnt", 64'(gnt_o), 64'h1);
    tick();
    req_i = 2'b00;
    tick();
    chk("rm_in_data", 64'(busy_o), 64'h1);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("rm_busy",   64'(busy_o),   64'h0);
    chk("rm_hsel",   64'(hsel_o),   64'h0);
    chk("rm_htrans", 64'(htrans_o), 64'h0);
    chk("rm_haddr",  64'(haddr_o),  64'h0);
    chk("rm_rvalid", 64'(rvalid_o), 64'h0);
    req_i  = 2'b11;
    aid_i  = 2'b10;
    addr_i = 64'h0000_0400_0000_0300;
    tick();
    chk("rm_gnt_rst", 64'(gnt_o), 64'h0);
    rst_ni = 1'b1;
    #1;
    chk("rm_gnt_en0", 64'(gnt_o), 64'h0);
    tick();

    // Round-robin with both ports requesting continuously.
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_oh;
      exp_oh = ((k % 2) == 0) ? 2'b01 : 2'b10;
      chk($sformatf("rr%0d_gnt", k), 64'(gnt_o), 64'(exp_oh));
      tick();
      chk($sformatf("rr%0d_haddr", k), 64'(haddr_o),
          ((k % 2) == 0) ? 64'h300 : 64'h400);
      tick();
      hrdata_i = 32'hA000_0000 + 32'(k);
      #1;
      tick();
      chk($sformatf("rr%0d_rvalid", k), 64'(rvalid_o), 64'(exp_oh));
      chk($sformatf("rr%0d_rdata", k),  64'(rdata_o),  64'(32'hA000_0000 + 32'(k)));
      chk($sformatf("rr%0d_rid", k),    64'(rid_o),    64'(k % 2));
      chk($sformatf("rr%0d_gnt_resp", k), 64'(gnt_o),  64'h0);
      tick();
    end
    req_i = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
